// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked add/sub unit.
//   state_t  : FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   MODE_ADD : mode value selecting a+b
//   MODE_SUB : mode value selecting a-b
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder slice.
//   x, y   : chunk operands
//   cin    : carry in (the running carry of the chained operation)
//   inv_y  : invert y before adding (subtract when combined with cin=1 on chunk 0)
//   s      : chunk sum
//   cout   : carry out of the chunk MSB
//   x_msb  : MSB of x as it entered the adder
//   y_msb  : MSB of the (possibly inverted) y, needed for signed overflow
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  input  logic             inv_y,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             x_msb,
  output logic             y_msb
);

  logic [CHUNK-1:0] y_eff;
  logic [CHUNK:0]   c;

  assign y_eff = inv_y ? ~y : y;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y_eff[i] ^ c[i];
      c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign x_msb = x[CHUNK-1];
  assign y_msb = y_eff[CHUNK-1];

endmodule

// File: rtl/addsub_chunked_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// cycle through a single carry-chained slice.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, mode)
//   out_valid/out_ready : result handshake (result, cout, ovf, zero)
//   cout                : carry (add) or borrow, 1 iff a<b unsigned (sub)
//   ovf                 : two's-complement overflow
//   zero                : result == 0
//   state_dbg           : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload while valid is high and not accepted;
// payload is only meaningful while valid is high. in_ready is 1 only in IDLE,
// so at most one operation is in flight. WIDTH must be a multiple of CHUNK.
module addsub_chunked_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic             carry_q;
  logic [CW-1:0]    k;

  logic [CHUNK-1:0] sl_x, sl_y, sl_s;
  logic             sl_cout, sl_x_msb, sl_y_msb;
  logic [WIDTH-1:0] res_next;
  logic             last_chunk;

  // Select the active chunk of the latched operands.
  always_comb begin
    sl_x = '0;
    sl_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k == CW'(i)) begin
        sl_x = a_q[i*CHUNK +: CHUNK];
        sl_y = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .x     (sl_x),
    .y     (sl_y),
    .cin   (carry_q),
    .inv_y (mode_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .x_msb (sl_x_msb),
    .y_msb (sl_y_msb)
  );

  // Result with the active chunk replaced by the slice sum.
  always_comb begin
    res_next = result;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k == CW'(i)) res_next[i*CHUNK +: CHUNK] = sl_s;
    end
  end

  assign last_chunk = (k == CW'(NCHUNK - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= MODE_ADD;
      carry_q   <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            mode_q   <= mode;
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            carry_q  <= mode;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          result  <= res_next;
          carry_q <= sl_cout;
          k       <= k + CW'(1);
          if (last_chunk) begin
            // Final carry is inverted in subtract mode to report a borrow.
            cout      <= (mode_q == MODE_SUB) ? ~sl_cout : sl_cout;
            ovf       <= (sl_x_msb ~^ sl_y_msb) & (sl_s[CHUNK-1] ^ sl_x_msb);
            zero      <= ~|res_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
